// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the dual-clock FIFO: wptr synchronizer, empty detect,
// RAM read issue and a 2-entry FWFT output buffer. Optional rd_count port via FIFO_RD_COUNT_EN.
module fifo_rd_ctrl #(
  parameter int DW          = 18,
  parameter int AW          = 7,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic          rclk,
  input  logic          rrst_n,
  input  logic [AW:0]   wptr_gray,
  output logic [AW:0]   rptr_gray,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] ram_rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          empty
`ifdef FIFO_RD_COUNT_EN
  ,
  output logic [AW:0]   rd_count
`endif
);

  typedef struct packed {
    logic [1:0][DW-1:0] slot;
    logic               head;
    logic [1:0]         cnt;
  } obuf_t;

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [SYNC_STAGES-1:0][AW:0] sync_q;
  logic [AW:0]                  wsync_bin;
  logic [AW:0]                  rptr;
  logic                         inflight;
  obuf_t                        obuf;
  logic [1:0]                   occ;
  logic                         pop;
  logic                         issue;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], wptr_gray};
  end

  assign wsync_bin = gray2bin(sync_q[SYNC_STAGES-1]);
  assign empty     = (rptr == wsync_bin);
  assign rd_addr   = rptr[AW-1:0];

  assign rd_valid  = (obuf.cnt != 2'd0);
  assign rd_data   = obuf.slot[obuf.head];
  assign pop       = rd_valid & rd_ready;
  assign occ       = obuf.cnt + {1'b0, inflight};
  // A pop frees a slot on the same edge, so a full pipe can still issue.
  assign issue     = !empty & ((occ < 2'd2) | pop);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rptr      <= '0;
      rptr_gray <= '0;
      inflight  <= 1'b0;
    end else begin
      if (issue) rptr <= rptr + 1'b1;
      rptr_gray <= rptr ^ (rptr >> 1);
      inflight  <= issue;
    end
  end

  // Capture only ever happens with cnt <= 1, so the write slot is head^cnt[0].
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      obuf <= '0;
    end else begin
      if (inflight) obuf.slot[obuf.head ^ obuf.cnt[0]] <= ram_rd_data;
      if (pop)      obuf.head <= ~obuf.head;
      obuf.cnt <= obuf.cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

`ifdef FIFO_RD_COUNT_EN
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) rd_count <= '0;
    else         rd_count <= (wsync_bin - rptr) + {{(AW-1){1'b0}}, obuf.cnt}
                             + {{AW{1'b0}}, inflight};
  end
`endif

endmodule
